// File: rtl/conv_1x1_accum_pkg.sv
// Shared types, constants and sizing helpers for the 1x1 convolution accumulator slice.
package conv_1x1_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned IMAGE_SIZE = 64 * 64;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  typedef enum logic [1:0] {
    S_FIRST,
    S_ACC,
    S_LAST
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_1x1_accum_if.sv
// Product stream in / accumulated pixel stream out for conv_1x1_accum.
interface conv_1x1_accum_if #(
  parameter int unsigned DATA_WIDTH = conv_1x1_pkg::DATA_WIDTH
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  done;

  modport master (
    output valid_in, pxl_in,
    input  pxl_out, valid_out, done
  );

  modport slave (
    input  valid_in, pxl_in,
    output pxl_out, valid_out, done
  );
endinterface

// File: rtl/conv_1x1_accum_fp_add.sv
// Pipelined FP32 adder: round-to-nearest-even, subnormals flushed to signed zero,
// canonical quiet NaN for invalid operations. Result emerges ADD_LATENCY cycles after valid.
module fp_add #(
  parameter int unsigned ADD_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        sum_valid,
  output logic [31:0] sum
);
  import conv_1x1_pkg::*;

  logic             sa, sb, s_big, swap;
  logic [EXP_W-1:0] ea, eb, e_big, e_small, d;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   m_big, m_small;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [55:0]      big_ext, sm_ext, mag;
  logic [5:0]       msb;
  logic [53:0]      norm;
  logic             rnd;
  logic [23:0]      frac_r;
  logic signed [10:0] exp_n, exp_f;
  logic [31:0]      res;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  always_comb begin
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);

    swap    = ({eb, fb} > {ea, fa});
    s_big   = swap ? sb : sa;
    e_big   = swap ? eb : ea;
    e_small = swap ? ea : eb;
    m_big   = swap ? {1'b1, fb} : {1'b1, fa};
    m_small = swap ? {1'b1, fa} : {1'b1, fb};
    d       = e_big - e_small;

    // Beyond 31 bits of alignment the smaller operand only matters as a sticky bit.
    big_ext = {1'b0, m_big, 31'b0};
    sm_ext  = (d > 8'd31) ? 56'd1 : ({1'b0, m_small, 31'b0} >> d);
    mag     = (sa ^ sb) ? (big_ext - sm_ext) : (big_ext + sm_ext);

    msb = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      if (mag[i]) msb = 6'(i);
    end

    if (msb == 6'd55) norm = {mag[54:2], |mag[1:0]};
    else              norm = 54'(mag << (6'd54 - msb));

    exp_n  = $signed({3'b000, e_big}) + $signed({5'b00000, msb}) - 11'sd54;
    rnd    = norm[30] & (norm[31] | (|norm[29:0]));
    frac_r = {1'b0, norm[53:31]} + {23'b0, rnd};
    exp_f  = exp_n + $signed({10'b0, frac_r[23]});

    if (a_nan || b_nan)          res = QNAN;
    else if (a_inf && b_inf)     res = (sa != sb) ? QNAN : a;
    else if (a_inf)              res = a;
    else if (b_inf)              res = b;
    else if (a_zero && b_zero)   res = {sa & sb, 31'b0};
    else if (a_zero)             res = b;
    else if (b_zero)             res = a;
    else if (mag == '0)          res = '0;
    else if (exp_f >= 11'sd255)  res = {s_big, 8'hFF, 23'b0};
    else if (exp_f <= 11'sd0)    res = {s_big, 31'b0};
    else                         res = {s_big, exp_f[7:0], frac_r[22:0]};
  end

  logic [ADD_LATENCY-1:0] vld_q;
  logic [31:0]            sum_q [ADD_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < ADD_LATENCY; i++) sum_q[i] <= '0;
    end else begin
      vld_q[0] <= valid;
      sum_q[0] <= res;
      for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        sum_q[i] <= sum_q[i-1];
      end
    end
  end

  assign sum_valid = vld_q[ADD_LATENCY-1];
  assign sum       = sum_q[ADD_LATENCY-1];

endmodule

// File: rtl/conv_1x1_accum.sv
// Per-pixel cross-channel accumulator behind the 1x1 conv multiplier, with frame-sized psum RAM.
// Optional ReLU on the final output: define CONV_1X1_ACCUM_RELU_EN.
module conv_1x1_accum #(
  parameter int unsigned IMAGE_WIDTH     = 64,
  parameter int unsigned IMAGE_HEIGHT    = 64,
  parameter int unsigned CHANNEL_NUM_IN  = 256,
  parameter int unsigned CHANNEL_NUM_OUT = 256,
  parameter int unsigned DATA_WIDTH      = conv_1x1_pkg::DATA_WIDTH,
  parameter int unsigned ADD_LATENCY     = 3
) (
  input logic             clk,
  input logic             reset,
  conv_1x1_accum_if.slave bus
);
  import conv_1x1_pkg::*;

  localparam int unsigned IMG_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned PIX_W    = cnt_w(IMG_SIZE);
  localparam int unsigned CH_W     = cnt_w(CHANNEL_NUM_IN);
  localparam int unsigned OC_W     = cnt_w(CHANNEL_NUM_OUT);

  state_t            state, state_nx;
  logic [PIX_W-1:0]  pix_cnt, pix_nx;
  logic [CH_W-1:0]   ch_cnt, ch_nx;
  logic [OC_W-1:0]   oc_cnt, oc_nx;
  logic              pix_last, ch_last, oc_last, is_last;

  assign pix_last = (pix_cnt == PIX_W'(IMG_SIZE - 1));
  assign ch_last  = (ch_cnt == CH_W'(CHANNEL_NUM_IN - 1));
  assign oc_last  = (oc_cnt == OC_W'(CHANNEL_NUM_OUT - 1));
  // With a single input channel the first and last channel are the same pass.
  assign is_last  = (state == S_LAST) || (CHANNEL_NUM_IN == 1);

  always_comb begin
    pix_nx   = pix_cnt;
    ch_nx    = ch_cnt;
    oc_nx    = oc_cnt;
    state_nx = state;
    if (bus.valid_in) begin
      pix_nx = pix_last ? '0 : pix_cnt + 1'b1;
      if (pix_last) begin
        ch_nx = ch_last ? '0 : ch_cnt + 1'b1;
        if (ch_last) oc_nx = oc_last ? '0 : oc_cnt + 1'b1;
      end
    end
    if (ch_nx == '0)                               state_nx = S_FIRST;
    else if (ch_nx == CH_W'(CHANNEL_NUM_IN - 1))   state_nx = S_LAST;
    else                                           state_nx = S_ACC;
  end

  logic                  rd_valid, rd_first, rd_last, rd_done;
  logic [PIX_W-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0] rd_pxl, rd_data, addend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FIRST;
      pix_cnt  <= '0;
      ch_cnt   <= '0;
      oc_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
      rd_done  <= 1'b0;
      rd_addr  <= '0;
      rd_pxl   <= '0;
    end else begin
      state    <= state_nx;
      pix_cnt  <= pix_nx;
      ch_cnt   <= ch_nx;
      oc_cnt   <= oc_nx;
      rd_valid <= bus.valid_in;
      rd_first <= (state == S_FIRST);
      rd_last  <= is_last;
      rd_done  <= is_last && pix_last && oc_last;
      rd_addr  <= pix_cnt;
      rd_pxl   <= bus.pxl_in;
    end
  end

  logic                  add_valid;
  logic [DATA_WIDTH-1:0] add_sum;
  logic [PIX_W-1:0]      sb_addr [ADD_LATENCY];
  logic [ADD_LATENCY-1:0] sb_last, sb_done;
  logic                  wb_en, out_fire;

  assign addend = rd_first ? '0 : rd_data;

  fp_add #(
    .ADD_LATENCY(ADD_LATENCY)
  ) u_add (
    .clk       (clk),
    .reset     (reset),
    .valid     (rd_valid),
    .a         (rd_pxl),
    .b         (addend),
    .sum_valid (add_valid),
    .sum       (add_sum)
  );

  // Pixel address and flags ride alongside the adder so write-back knows where to land.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_last <= '0;
      sb_done <= '0;
      for (int unsigned i = 0; i < ADD_LATENCY; i++) sb_addr[i] <= '0;
    end else begin
      sb_last[0] <= rd_last;
      sb_done[0] <= rd_done;
      sb_addr[0] <= rd_addr;
      for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
        sb_last[i] <= sb_last[i-1];
        sb_done[i] <= sb_done[i-1];
        sb_addr[i] <= sb_addr[i-1];
      end
    end
  end

  assign wb_en    = add_valid & ~sb_last[ADD_LATENCY-1];
  assign out_fire = add_valid &  sb_last[ADD_LATENCY-1];

  logic [DATA_WIDTH-1:0] psum [IMG_SIZE];

  always_ff @(posedge clk) begin
    if (bus.valid_in) rd_data <= psum[pix_cnt];
    if (wb_en) psum[sb_addr[ADD_LATENCY-1]] <= add_sum;
  end

  logic [DATA_WIDTH-1:0] pxl_res;

  always_comb begin
    pxl_res = add_sum;
`ifdef CONV_1X1_ACCUM_RELU_EN
    if (add_sum[DATA_WIDTH-1]) pxl_res = '0;
`else
    pxl_res = add_sum;
`endif
  end

  assign bus.pxl_out   = out_fire ? pxl_res : '0;
  assign bus.valid_out = out_fire;
  assign bus.done      = out_fire & sb_done[ADD_LATENCY-1];

endmodule

// File: tb/tb_conv_1x1_accum.sv
// Randomized self-checking bench for conv_1x1_accum against a real-arithmetic reference model.
module tb_conv_1x1_accum;
  localparam int unsigned CI = 3;
  localparam int unsigned SZ = 16;
  localparam int unsigned FR = CI * SZ;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stray = 0;

  conv_1x1_accum_if #(.DATA_WIDTH(32)) bus ();

  conv_1x1_accum #(
    .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2),
    .DATA_WIDTH(32), .ADD_LATENCY(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mon_pxl[$];
  int          mon_cyc[$];
  logic        mon_done[$];
  int          in_cyc[$];
  logic [31:0] stim[$];
  logic [31:0] exp_pxl[$];
  int          exp_cyc[$];
  logic        exp_done[$];
  logic [31:0] ramp_ref[$];

  always @(negedge clk) begin
    if (bus.valid_out) begin
      mon_pxl.push_back(bus.pxl_out);
      mon_cyc.push_back(cyc);
      mon_done.push_back(bus.done);
    end
    if (bus.done && !bus.valid_out) stray++;
  end

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real  m, sc, fl, fr;
    int   e, fi;
    logic s;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    sc = (m - 1.0) * 8388608.0;
    fl = $floor(sc);
    fr = sc - fl;
    fi = $rtoi(fl);
    if (fr > 0.5 || (fr == 0.5 && (fi % 2) == 1)) fi++;
    if (fi == 8388608) begin fi = 0; e++; end
    e += 127;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), 23'(fi)};
  endfunction

  function automatic logic [31:0] fadd_m(input logic [31:0] a, input logic [31:0] b);
    logic an, bn, ai, bi, az, bz;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn) return 32'h7FC00000;
    if (ai && bi) return (a[31] != b[31]) ? 32'h7FC00000 : a;
    if (ai) return a;
    if (bi) return b;
    if (az && bz) return {a[31] & b[31], 31'h0};
    if (az) return b;
    if (bz) return a;
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CONV_1X1_ACCUM_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] rand_f();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(132, 118)), 23'($urandom)};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      bus.pxl_in   = $urandom;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.valid_in = 1'b1;
    bus.pxl_in   = 32'h4B000000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.valid_in = 1'b0;
    mon_pxl.delete(); mon_cyc.delete(); mon_done.delete(); in_cyc.delete();
    stray = 0;
  endtask

  task automatic run_stream(input int unsigned gap_max);
    for (int i = 0; i < stim.size(); i++) begin
      if (gap_max != 0) idle($urandom_range(gap_max, 0));
      @(posedge clk); #1;
      bus.valid_in = 1'b1;
      bus.pxl_in   = stim[i];
      in_cyc.push_back(cyc);
    end
    idle(12);
  endtask

  task automatic build_expect();
    logic [31:0] acc;
    exp_pxl.delete(); exp_cyc.delete(); exp_done.delete();
    for (int blk = 0; blk < stim.size() / FR; blk++) begin
      for (int p = 0; p < SZ; p++) begin
        acc = 32'h0;
        for (int c = 0; c < CI; c++) acc = fadd_m(stim[blk*FR + c*SZ + p], acc);
        exp_pxl.push_back(relu(acc));
        exp_cyc.push_back(in_cyc[blk*FR + (CI-1)*SZ + p] + LAT);
        exp_done.push_back((blk % 2 == 1) && (p == SZ - 1));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (bus.pxl_out !== 32'h0) begin n_bad++; $display("FAIL reset_pxl_out: got %h want 00000000", bus.pxl_out); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
  endtask

  task automatic test_ones();
    do_reset();
    stim.delete();
    repeat (FR) stim.push_back(32'h3F800000);
    run_stream(0);
    n_cmp++; if (mon_pxl.size() != SZ) begin n_bad++; $display("FAIL ones_count: got %0d want %0d", mon_pxl.size(), SZ); end
    for (int i = 0; i < mon_pxl.size() && i < SZ; i++) begin
      n_cmp++; if (mon_pxl[i] !== 32'h40400000) begin n_bad++; $display("FAIL ones_value[%0d]: got %h want 40400000", i, mon_pxl[i]); end
      n_cmp++; if (mon_cyc[i] !== in_cyc[32+i] + LAT) begin n_bad++; $display("FAIL ones_latency[%0d]: got cyc %0d want %0d", i, mon_cyc[i], in_cyc[32+i] + LAT); end
      n_cmp++; if (mon_done[i] !== 1'b0) begin n_bad++; $display("FAIL ones_done[%0d]: got 1 want 0", i); end
    end
    n_cmp++; if (mon_cyc.size() == 0 || mon_cyc[0] <= in_cyc[31]) begin n_bad++; $display("FAIL ones_early_output: outputs %0d, first at cyc %0d", mon_cyc.size(), (mon_cyc.size() != 0) ? mon_cyc[0] : -1); end
  endtask

  task automatic test_ramp(input int unsigned gap_max, input bit save_ref);
    do_reset();
    stim.delete();
    for (int oc = 0; oc < 2; oc++)
      for (int c = 0; c < CI; c++)
        for (int p = 0; p < SZ; p++) stim.push_back(r2f(real'(p + c)));
    run_stream(gap_max);
    build_expect();
    n_cmp++; if (mon_pxl.size() != exp_pxl.size()) begin n_bad++; $display("FAIL ramp_count(gap%0d): got %0d want %0d", gap_max, mon_pxl.size(), exp_pxl.size()); end
    for (int i = 0; i < exp_pxl.size() && i < mon_pxl.size(); i++) begin
      n_cmp++; if (mon_pxl[i] !== exp_pxl[i]) begin n_bad++; $display("FAIL ramp_value(gap%0d)[%0d]: got %h want %h", gap_max, i, mon_pxl[i], exp_pxl[i]); end
      n_cmp++; if (mon_cyc[i] !== exp_cyc[i]) begin n_bad++; $display("FAIL ramp_latency(gap%0d)[%0d]: got cyc %0d want %0d", gap_max, i, mon_cyc[i], exp_cyc[i]); end
      n_cmp++; if (mon_done[i] !== exp_done[i]) begin n_bad++; $display("FAIL ramp_done(gap%0d)[%0d]: got %b want %b", gap_max, i, mon_done[i], exp_done[i]); end
      if (!save_ref && i < ramp_ref.size()) begin
        n_cmp++; if (mon_pxl[i] !== ramp_ref[i]) begin n_bad++; $display("FAIL gap_vs_nogap[%0d]: got %h want %h", i, mon_pxl[i], ramp_ref[i]); end
      end
    end
    n_cmp++; if (mon_pxl.size() < 6 || mon_pxl[5] !== 32'h41900000) begin n_bad++; $display("FAIL ramp_p5(gap%0d): got %h want 41900000", gap_max, (mon_pxl.size() >= 6) ? mon_pxl[5] : 32'hx); end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL ramp_stray_done(gap%0d): got %0d want 0", gap_max, stray); end
    if (save_ref) ramp_ref = mon_pxl;
  endtask

  task automatic test_mixed();
    logic [31:0] want;
`ifdef CONV_1X1_ACCUM_RELU_EN
    want = 32'h00000000;
`else
    want = 32'hBF800000;
`endif
    do_reset();
    stim.delete();
    repeat (SZ) stim.push_back(32'h40200000);
    repeat (SZ) stim.push_back(32'hC0800000);
    repeat (SZ) stim.push_back(32'h3F000000);
    run_stream(0);
    n_cmp++; if (mon_pxl.size() != SZ) begin n_bad++; $display("FAIL mixed_count: got %0d want %0d", mon_pxl.size(), SZ); end
    for (int i = 0; i < mon_pxl.size(); i++) begin
      n_cmp++; if (mon_pxl[i] !== want) begin n_bad++; $display("FAIL mixed_value[%0d]: got %h want %h", i, mon_pxl[i], want); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stim.delete();
    repeat (20) stim.push_back(rand_f());
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b1;
      bus.pxl_in   = stim[i];
    end
    do_reset();
    stim.delete();
    repeat (FR) stim.push_back(32'h3F800000);
    run_stream(0);
    n_cmp++; if (mon_pxl.size() != SZ) begin n_bad++; $display("FAIL rstmid_count: got %0d want %0d", mon_pxl.size(), SZ); end
    for (int i = 0; i < mon_pxl.size() && i < SZ; i++) begin
      n_cmp++; if (mon_pxl[i] !== 32'h40400000) begin n_bad++; $display("FAIL rstmid_value[%0d]: got %h want 40400000", i, mon_pxl[i]); end
      n_cmp++; if (mon_cyc[i] !== in_cyc[32+i] + LAT) begin n_bad++; $display("FAIL rstmid_latency[%0d]: got cyc %0d want %0d", i, mon_cyc[i], in_cyc[32+i] + LAT); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    stim.delete();
    repeat (SZ) stim.push_back(32'h7F7FFFFF);
    repeat (SZ) stim.push_back(32'h7F7FFFFF);
    repeat (SZ) stim.push_back(32'h00000000);
    run_stream(0);
    n_cmp++; if (mon_pxl.size() != SZ) begin n_bad++; $display("FAIL ovf_count: got %0d want %0d", mon_pxl.size(), SZ); end
    for (int i = 0; i < mon_pxl.size(); i++) begin
      n_cmp++; if (mon_pxl[i] !== 32'h7F800000) begin n_bad++; $display("FAIL ovf_value[%0d]: got %h want 7F800000", i, mon_pxl[i]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    stim.delete();
    repeat (2 * FR) stim.push_back(rand_f());
    run_stream(2);
    build_expect();
    n_cmp++; if (mon_pxl.size() != exp_pxl.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", mon_pxl.size(), exp_pxl.size()); end
    for (int i = 0; i < exp_pxl.size() && i < mon_pxl.size(); i++) begin
      n_cmp++; if (mon_pxl[i] !== exp_pxl[i]) begin n_bad++; $display("FAIL rand_value[%0d]: got %h want %h", i, mon_pxl[i], exp_pxl[i]); end
      n_cmp++; if (mon_cyc[i] !== exp_cyc[i]) begin n_bad++; $display("FAIL rand_latency[%0d]: got cyc %0d want %0d", i, mon_cyc[i], exp_cyc[i]); end
      n_cmp++; if (mon_done[i] !== exp_done[i]) begin n_bad++; $display("FAIL rand_done[%0d]: got %b want %b", i, mon_done[i], exp_done[i]); end
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.pxl_in   = 32'h0;
    test_reset();
    test_ones();
    test_ramp(0, 1'b1);
    test_ramp(3, 1'b0);
    test_mixed();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
